// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage.
//   DATA_W / REG_AW / OP_W : default datapath, register-index and opcode widths
//   ALUOP_*                : ALU opcode encodings (ALUOP_NOP is driven while EX holds a bubble)
//   fwd_sel_e              : operand source chosen by the forwarding unit
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALUOP_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALUOP_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALUOP_OR  = 3'b010;
    localparam logic [OP_W-1:0] ALUOP_AND = 3'b011;
    localparam logic [OP_W-1:0] ALUOP_NOT = 3'b100;
    localparam logic [OP_W-1:0] ALUOP_NOP = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,  // value latched in ID/EX
        FWD_EXMEM = 2'b01,  // result sitting in EX/MEM
        FWD_WB    = 2'b10   // data being written back from MEM/WB
    } fwd_sel_e;

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Signal bundle between the execute stage and its neighbours (ID stage, MEM/WB
// stage, external ALU, EX/MEM consumers).
//   slave  : the execute stage (ex_stage_pipe)
//   master : the surrounding pipeline / testbench
// Groups: pipeline control (stall, flush), ID inputs (id_*), write-back forward
// source (wb_*), ALU operands/result (alu_*), EX/MEM register outputs (exmem_*).
interface ex_stage_pipe_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int OP_W   = mips_pkg::OP_W
);
    logic              stall;
    logic              flush;

    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dst;
    logic [OP_W-1:0]   id_aluop;
    logic              id_alusrc;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;

    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    logic              exmem_valid;
    logic [DATA_W-1:0] exmem_result;
    logic              exmem_zero;
    logic [DATA_W-1:0] exmem_store;
    logic [REG_AW-1:0] exmem_dst;
    logic              exmem_regwrite;
    logic              exmem_memread;
    logic              exmem_memwrite;

    modport slave (
        input  stall, flush,
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_dst,
        input  id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
        input  wb_regwrite, wb_dst, wb_data,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_zero,
        output exmem_valid, exmem_result, exmem_zero, exmem_store, exmem_dst,
        output exmem_regwrite, exmem_memread, exmem_memwrite
    );

    modport master (
        output stall, flush,
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_dst,
        output id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite,
        output wb_regwrite, wb_dst, wb_data,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_zero,
        input  exmem_valid, exmem_result, exmem_zero, exmem_store, exmem_dst,
        input  exmem_regwrite, exmem_memread, exmem_memwrite
    );

endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU source operand (instantiated once for rs, once for rt).
//   src            in  source register index held in ID/EX
//   exmem_valid    in  EX/MEM holds a real instruction
//   exmem_regwrite in  EX/MEM instruction writes the register file
//   exmem_memread  in  EX/MEM instruction is a load (its result is an address, not data)
//   exmem_dst      in  EX/MEM destination index
//   wb_regwrite    in  MEM/WB write enable
//   wb_dst         in  MEM/WB destination index
//   sel            out operand source; EX/MEM wins over MEM/WB as it is the younger producer
module fwd_unit #(
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0]   src,
    input  logic                exmem_valid,
    input  logic                exmem_regwrite,
    input  logic                exmem_memread,
    input  logic [REG_AW-1:0]   exmem_dst,
    input  logic                wb_regwrite,
    input  logic [REG_AW-1:0]   wb_dst,
    output mips_pkg::fwd_sel_e  sel
);
    import mips_pkg::*;

    logic exmem_hit;
    logic wb_hit;

    // Register 0 is hard-wired to zero, so a write to it is never a real producer.
    assign exmem_hit = exmem_valid && exmem_regwrite && !exmem_memread &&
                       (exmem_dst != '0) && (exmem_dst == src);
    assign wb_hit    = wb_regwrite && (wb_dst != '0) && (wb_dst == src);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        sel = FWD_REG;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register, operand forwarding,
// ALU operand/opcode drive, and the EX/MEM register.
//   clk   in  rising-edge clock
//   reset in  synchronous, active-high; clears both pipeline registers
//   bus   slave modport of ex_stage_pipe_if (stall/flush, id_*, wb_*, alu_*, exmem_*)
// Latency: ID fields captured at edge N, ALU evaluates during cycle N, EX/MEM at edge N+1.
module ex_stage_pipe #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int OP_W   = mips_pkg::OP_W
) (
    input  logic           clk,
    input  logic           reset,
    ex_stage_pipe_if.slave bus
);
    import mips_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dst;
        logic [OP_W-1:0]   aluop;
        logic              alusrc;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              zero;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] dst;
    } exmem_t;

    idex_t             idex_q;
    idex_t             idex_load;
    exmem_t            exmem_q;
    fwd_sel_e          sel_rs;
    fwd_sel_e          sel_rt;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // ------------------------------------------------------------ ID/EX
    always_comb begin
        idex_load          = '0;
        idex_load.valid    = bus.id_valid;
        idex_load.rs_data  = bus.id_rs_data;
        idex_load.rt_data  = bus.id_rt_data;
        idex_load.imm      = bus.id_imm;
        idex_load.rs       = bus.id_rs;
        idex_load.rt       = bus.id_rt;
        idex_load.dst      = bus.id_dst;
        idex_load.aluop    = bus.id_aluop;
        idex_load.alusrc   = bus.id_alusrc;
        idex_load.regwrite = bus.id_regwrite;
        idex_load.memread  = bus.id_memread;
        idex_load.memwrite = bus.id_memwrite;
    end

    // Flush outranks stall: a squashed instruction must not be held in EX.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            idex_q <= '0;
        end else if (bus.flush) begin
            idex_q <= '0;
        end else if (!bus.stall) begin
            idex_q <= idex_load;
        end
    end

    // ------------------------------------------------------------ forwarding
    fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs (
        .src            (idex_q.rs),
        .exmem_valid    (exmem_q.valid),
        .exmem_regwrite (exmem_q.regwrite),
        .exmem_memread  (exmem_q.memread),
        .exmem_dst      (exmem_q.dst),
        .wb_regwrite    (bus.wb_regwrite),
        .wb_dst         (bus.wb_dst),
        .sel            (sel_rs)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_rt (
        .src            (idex_q.rt),
        .exmem_valid    (exmem_q.valid),
        .exmem_regwrite (exmem_q.regwrite),
        .exmem_memread  (exmem_q.memread),
        .exmem_dst      (exmem_q.dst),
        .wb_regwrite    (bus.wb_regwrite),
        .wb_dst         (bus.wb_dst),
        .sel            (sel_rt)
    );

    always_comb begin
        fwd_rs = idex_q.rs_data;
        case (sel_rs)
            FWD_EXMEM: fwd_rs = exmem_q.result;
            FWD_WB:    fwd_rs = bus.wb_data;
            default:   fwd_rs = idex_q.rs_data;
        endcase
    end

    always_comb begin
        fwd_rt = idex_q.rt_data;
        case (sel_rt)
            FWD_EXMEM: fwd_rt = exmem_q.result;
            FWD_WB:    fwd_rt = bus.wb_data;
            default:   fwd_rt = idex_q.rt_data;
        endcase
    end

    // ------------------------------------------------------------ ALU drive
    assign bus.alu_a  = fwd_rs;
    assign bus.alu_b  = idex_q.alusrc ? idex_q.imm : fwd_rt;
    assign bus.alu_op = idex_q.valid ? idex_q.aluop : ALUOP_NOP;

    // ------------------------------------------------------------ EX/MEM
    // A stall leaves the instruction in EX, so the slot behind it in MEM is a bubble.
    // Data fields are don't-care in a bubble; only the valid/control bits are cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_q <= '0;
        end else if (bus.stall) begin
            exmem_q.valid    <= 1'b0;
            exmem_q.regwrite <= 1'b0;
            exmem_q.memread  <= 1'b0;
            exmem_q.memwrite <= 1'b0;
        end else begin
            exmem_q.valid    <= idex_q.valid;
            exmem_q.regwrite <= idex_q.valid & idex_q.regwrite;
            exmem_q.memread  <= idex_q.valid & idex_q.memread;
            exmem_q.memwrite <= idex_q.valid & idex_q.memwrite;
            exmem_q.zero     <= bus.alu_zero;
            exmem_q.result   <= bus.alu_out;
            exmem_q.store    <= fwd_rt;
            exmem_q.dst      <= idex_q.dst;
        end
    end

    assign bus.exmem_valid    = exmem_q.valid;
    assign bus.exmem_result   = exmem_q.result;
    assign bus.exmem_zero     = exmem_q.zero;
    assign bus.exmem_store    = exmem_q.store;
    assign bus.exmem_dst      = exmem_q.dst;
    assign bus.exmem_regwrite = exmem_q.regwrite;
    assign bus.exmem_memread  = exmem_q.memread;
    assign bus.exmem_memwrite = exmem_q.memwrite;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe. The bench plays the external ALU and the
// neighbouring pipeline stages; outputs are sampled 1 ns after each rising edge.
module tb_ex_stage_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_stage_pipe_if bus ();

    ex_stage_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference ALU.
    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            3'b011:  return a & b;
            3'b100:  return ~a;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_out  = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (alu_model(bus.alu_op, bus.alu_a, bus.alu_b) == 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid    = 1'b0;
        bus.id_rs_data  = '0;
        bus.id_rt_data  = '0;
        bus.id_imm      = '0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_dst      = '0;
        bus.id_aluop    = '0;
        bus.id_alusrc   = 1'b0;
        bus.id_regwrite = 1'b0;
        bus.id_memread  = 1'b0;
        bus.id_memwrite = 1'b0;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [31:0] rs_data,
                            input logic [4:0] rt, input logic [31:0] rt_data,
                            input logic [31:0] imm, input logic alusrc,
                            input logic [2:0] op, input logic [4:0] dst,
                            input logic regwrite, input logic memwrite);
        bus.id_valid    = 1'b1;
        bus.id_rs       = rs;
        bus.id_rs_data  = rs_data;
        bus.id_rt       = rt;
        bus.id_rt_data  = rt_data;
        bus.id_imm      = imm;
        bus.id_alusrc   = alusrc;
        bus.id_aluop    = op;
        bus.id_dst      = dst;
        bus.id_regwrite = regwrite;
        bus.id_memread  = 1'b0;
        bus.id_memwrite = memwrite;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] dst, input logic [31:0] data);
        bus.wb_regwrite = we;
        bus.wb_dst      = dst;
        bus.wb_data     = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.stall       = 1'($urandom);
            bus.flush       = 1'($urandom);
            bus.id_valid    = 1'($urandom);
            bus.id_rs_data  = $urandom;
            bus.id_rt_data  = $urandom;
            bus.id_imm      = $urandom;
            bus.id_rs       = 5'($urandom);
            bus.id_rt       = 5'($urandom);
            bus.id_dst      = 5'($urandom);
            bus.id_aluop    = 3'($urandom);
            bus.id_alusrc   = 1'($urandom);
            bus.id_regwrite = 1'($urandom);
            bus.id_memread  = 1'($urandom);
            bus.id_memwrite = 1'($urandom);
            set_wb(1'($urandom), 5'($urandom), $urandom);
            tick();
        end
        checks++; if (bus.exmem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.exmem_valid); end
        checks++; if (bus.exmem_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.exmem_result); end
        checks++; if (bus.exmem_store !== 32'd0) begin errors++; $display("FAIL reset_store: got %h expected 0", bus.exmem_store); end
        checks++; if (bus.exmem_dst !== 5'd0) begin errors++; $display("FAIL reset_dst: got %0d expected 0", bus.exmem_dst); end
        checks++; if ({bus.exmem_regwrite, bus.exmem_memread, bus.exmem_memwrite, bus.exmem_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.exmem_regwrite, bus.exmem_memread, bus.exmem_memwrite, bus.exmem_zero}); end
        checks++; if (bus.alu_op !== 3'b111) begin errors++; $display("FAIL reset_aluop: got %b expected 111", bus.alu_op); end

        // First instruction out of reset: add r3 = r1(5) + r2(7).
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        drive_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, ALUOP_ADD, 5'd3, 1'b1, 1'b0);
        tick();
        clear_id();
        checks++; if (bus.alu_a !== 32'd5) begin errors++; $display("FAIL first_alu_a: got %h expected 5", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd7) begin errors++; $display("FAIL first_alu_b: got %h expected 7", bus.alu_b); end
        checks++; if (bus.exmem_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid: got %b expected 0", bus.exmem_valid); end
        tick();
        checks++; if (bus.exmem_result !== 32'd12) begin errors++; $display("FAIL first_result: got %h expected c", bus.exmem_result); end
        checks++; if (bus.exmem_dst !== 5'd3) begin errors++; $display("FAIL first_dst: got %0d expected 3", bus.exmem_dst); end
        checks++; if ({bus.exmem_valid, bus.exmem_regwrite} !== 2'b11) begin errors++; $display("FAIL first_valid_rw: got %b expected 11", {bus.exmem_valid, bus.exmem_regwrite}); end
    endtask

    task automatic test_back_to_back();
        drive_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, ALUOP_ADD, 5'd3, 1'b1, 1'b0);
        tick();
        // sub r4 = r3 - r1, with a stale rs read of 0 from the register file.
        drive_id(5'd3, 32'd0, 5'd1, 32'd5, 32'd0, 1'b0, ALUOP_SUB, 5'd4, 1'b1, 1'b0);
        tick();
        clear_id();
        checks++; if (bus.alu_a !== 32'd12) begin errors++; $display("FAIL b2b_fwd_exmem: got %h expected c", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd5) begin errors++; $display("FAIL b2b_alu_b: got %h expected 5", bus.alu_b); end
        checks++; if (bus.alu_op !== ALUOP_SUB) begin errors++; $display("FAIL b2b_alu_op: got %b expected 001", bus.alu_op); end
        tick();
        checks++; if (bus.exmem_result !== 32'd7) begin errors++; $display("FAIL b2b_result: got %h expected 7", bus.exmem_result); end
        checks++; if (bus.exmem_dst !== 5'd4) begin errors++; $display("FAIL b2b_dst: got %0d expected 4", bus.exmem_dst); end
    endtask

    task automatic test_ops_zero();
        drive_id(5'd20, 32'h0000_F0F0, 5'd21, 32'h0000_FF00, 32'd0, 1'b0, ALUOP_AND, 5'd22, 1'b1, 1'b0);
        tick();
        checks++; if (bus.alu_op !== ALUOP_AND) begin errors++; $display("FAIL and_alu_op: got %b expected 011", bus.alu_op); end
        drive_id(5'd23, 32'd9, 5'd24, 32'd9, 32'd0, 1'b0, ALUOP_SUB, 5'd25, 1'b1, 1'b0);
        tick();
        clear_id();
        checks++; if ({bus.exmem_result, bus.exmem_zero} !== {32'h0000_F000, 1'b0}) begin
            errors++; $display("FAIL and_result: got %h/%b expected 0000f000/0", bus.exmem_result, bus.exmem_zero); end
        tick();
        checks++; if ({bus.exmem_result, bus.exmem_zero} !== {32'd0, 1'b1}) begin
            errors++; $display("FAIL sub_zero: got %h/%b expected 00000000/1", bus.exmem_result, bus.exmem_zero); end
    endtask

    task automatic test_forward_priority();
        // Producer: r5 = 0 + 0x200.
        drive_id(5'd0, 32'd0, 5'd0, 32'd0, 32'h200, 1'b1, ALUOP_ADD, 5'd5, 1'b1, 1'b0);
        tick();
        // Consumer: r6 = r5 + 0, stale rs read of 0.
        drive_id(5'd5, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, ALUOP_ADD, 5'd6, 1'b1, 1'b0);
        tick();
        set_wb(1'b1, 5'd5, 32'h100);
        #1;
        checks++; if (bus.alu_a !== 32'h200) begin errors++; $display("FAIL fwd_exmem_over_wb: got %h expected 200", bus.alu_a); end
        // Stall drops EX/MEM to a bubble, so only the WB source remains.
        bus.stall = 1'b1;
        tick();
        checks++; if (bus.exmem_regwrite !== 1'b0) begin errors++; $display("FAIL fwd_bubble_rw: got %b expected 0", bus.exmem_regwrite); end
        checks++; if (bus.alu_a !== 32'h100) begin errors++; $display("FAIL fwd_wb: got %h expected 100", bus.alu_a); end
        set_wb(1'b1, 5'd0, 32'h100);
        #1;
        checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL fwd_none: got %h expected 0", bus.alu_a); end
        // Register 0 source must read ID/EX data even while WB writes index 0.
        bus.stall = 1'b0;
        drive_id(5'd0, 32'h33, 5'd0, 32'd0, 32'd0, 1'b1, ALUOP_ADD, 5'd7, 1'b1, 1'b0);
        tick();
        checks++; if (bus.alu_a !== 32'h33) begin errors++; $display("FAIL fwd_reg0: got %h expected 33", bus.alu_a); end
        checks++; if ({bus.exmem_dst, bus.exmem_result} !== {5'd6, 32'd0}) begin
            errors++; $display("FAIL fwd_consumer_out: got dst %0d res %h expected dst 6 res 0", bus.exmem_dst, bus.exmem_result); end
        clear_id();
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (bus.exmem_result !== 32'h33) begin errors++; $display("FAIL reg0_result: got %h expected 33", bus.exmem_result); end
    endtask

    task automatic test_stall();
        drive_id(5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, ALUOP_ADD, 5'd8, 1'b1, 1'b0);
        tick();
        drive_id(5'd10, 32'h0F0, 5'd11, 32'h00F, 32'd0, 1'b0, ALUOP_OR, 5'd9, 1'b1, 1'b0);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.exmem_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 0", i, bus.exmem_valid); end
            checks++; if ({bus.alu_a, bus.alu_b} !== {32'd3, 32'd4}) begin
                errors++; $display("FAIL stall_hold_%0d: got %h/%h expected 3/4", i, bus.alu_a, bus.alu_b); end
        end
        bus.stall = 1'b0;
        tick();
        clear_id();
        checks++; if ({bus.exmem_valid, bus.exmem_dst, bus.exmem_result} !== {1'b1, 5'd8, 32'd7}) begin
            errors++; $display("FAIL stall_resume_a: got v%b dst %0d res %h expected v1 dst 8 res 7", bus.exmem_valid, bus.exmem_dst, bus.exmem_result); end
        tick();
        checks++; if ({bus.exmem_dst, bus.exmem_result} !== {5'd9, 32'hFF}) begin
            errors++; $display("FAIL stall_resume_b: got dst %0d res %h expected dst 9 res ff", bus.exmem_dst, bus.exmem_result); end
    endtask

    task automatic test_stall_flush();
        drive_id(5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, ALUOP_ADD, 5'd12, 1'b1, 1'b1);
        tick();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        checks++; if (bus.alu_op !== 3'b111) begin errors++; $display("FAIL flush_alu_op: got %b expected 111", bus.alu_op); end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_id();
        tick();
        checks++; if ({bus.exmem_valid, bus.exmem_regwrite, bus.exmem_memwrite} !== 3'b000) begin
            errors++; $display("FAIL flush_bubble: got %b expected 000", {bus.exmem_valid, bus.exmem_regwrite, bus.exmem_memwrite}); end
    endtask

    task automatic test_store_wrap();
        // sw: addr = 0x10 + 0xFFFFFFFC, store data r14 forwarded from WB.
        set_wb(1'b1, 5'd14, 32'hDEAD);
        drive_id(5'd13, 32'h10, 5'd14, 32'd0, 32'hFFFF_FFFC, 1'b1, ALUOP_ADD, 5'd0, 1'b0, 1'b1);
        tick();
        checks++; if ({bus.alu_a, bus.alu_b} !== {32'h10, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL sw_operands: got %h/%h expected 10/fffffffc", bus.alu_a, bus.alu_b); end
        drive_id(5'd15, 32'h7FFF_FFFF, 5'd16, 32'd1, 32'd0, 1'b0, ALUOP_ADD, 5'd17, 1'b1, 1'b0);
        tick();
        clear_id();
        set_wb(1'b0, 5'd0, 32'd0);
        checks++; if (bus.exmem_result !== 32'hC) begin errors++; $display("FAIL sw_addr: got %h expected c", bus.exmem_result); end
        checks++; if (bus.exmem_store !== 32'hDEAD) begin errors++; $display("FAIL sw_store: got %h expected dead", bus.exmem_store); end
        checks++; if ({bus.exmem_memwrite, bus.exmem_regwrite} !== 2'b10) begin
            errors++; $display("FAIL sw_ctrl: got %b expected 10", {bus.exmem_memwrite, bus.exmem_regwrite}); end
        tick();
        checks++; if (bus.exmem_result !== 32'h8000_0000) begin errors++; $display("FAIL add_wrap: got %h expected 80000000", bus.exmem_result); end
    endtask

    task automatic test_reset_mid();
        drive_id(5'd1, 32'd9, 5'd2, 32'd9, 32'd0, 1'b0, ALUOP_ADD, 5'd18, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({bus.exmem_valid, bus.exmem_regwrite, bus.exmem_result} !== {1'b0, 1'b0, 32'd0}) begin
            errors++; $display("FAIL rstmid_exmem: got v%b rw%b res %h expected all 0", bus.exmem_valid, bus.exmem_regwrite, bus.exmem_result); end
        checks++; if (bus.alu_op !== 3'b111) begin errors++; $display("FAIL rstmid_alu_op: got %b expected 111", bus.alu_op); end
        reset = 1'b0;
        clear_id();
        tick();
        checks++; if (bus.exmem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got %b expected 0", bus.exmem_valid); end
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_id();
        set_wb(1'b0, 5'd0, 32'd0);
        test_reset();
        test_back_to_back();
        test_ops_zero();
        test_forward_priority();
        test_stall();
        test_stall_flush();
        test_store_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
